// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - ripple-carry adder split into STAGES valid/ready pipeline slices
// Optional signed-overflow output enabled by defining PIPELINED_ADDER_OVF_EN.
module pipelined_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             out_valid,
`ifdef PIPELINED_ADDER_OVF_EN
  output logic             overflow,
`endif
  input  logic             out_ready
);

  localparam int SLICE = WIDTH / STAGES;

  logic [STAGES:0] rdy;

  assign rdy[STAGES] = out_ready;
  assign in_ready    = rdy[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // op_a/op_b hold only the not-yet-added slices; the low SLICE bits are this stage's slice
    localparam int IN_W = WIDTH - k * SLICE;

    logic [IN_W-1:0]  op_a;
    logic [IN_W-1:0]  op_b;
    logic             in_v;
    logic             in_c;
    logic [WIDTH-1:0] in_sum;
    logic [SLICE:0]   slice_res;
    logic [WIDTH-1:0] sum_d;
    logic             v_q;
    logic             carry_q;
    logic [WIDTH-1:0] sum_q;

    if (k == 0) begin : g_head
      assign op_a   = a;
      assign op_b   = b;
      assign in_v   = in_valid;
      assign in_c   = carry_in;
      assign in_sum = '0;
    end else begin : g_body
      // Upper operand slices travel with the previous stage, loaded on its enable
      logic [IN_W-1:0] a_rem_q;
      logic [IN_W-1:0] b_rem_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_rem_q <= '0;
          b_rem_q <= '0;
        end else if (rdy[k-1]) begin
          a_rem_q <= g_stage[k-1].op_a[IN_W+SLICE-1:SLICE];
          b_rem_q <= g_stage[k-1].op_b[IN_W+SLICE-1:SLICE];
        end
      end

      assign op_a   = a_rem_q;
      assign op_b   = b_rem_q;
      assign in_v   = g_stage[k-1].v_q;
      assign in_c   = g_stage[k-1].carry_q;
      assign in_sum = g_stage[k-1].sum_q;
    end

    assign rdy[k]    = !v_q || rdy[k+1];
    assign slice_res = {1'b0, op_a[SLICE-1:0]} + {1'b0, op_b[SLICE-1:0]}
                     + {{SLICE{1'b0}}, in_c};

    always_comb begin
      sum_d                    = in_sum;
      sum_d[k*SLICE +: SLICE] = slice_res[SLICE-1:0];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q     <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (rdy[k]) begin
        v_q     <= in_v;
        carry_q <= slice_res[SLICE];
        sum_q   <= sum_d;
      end
    end
  end

  assign sum       = g_stage[STAGES-1].sum_q;
  assign carry_out = g_stage[STAGES-1].carry_q;
  assign out_valid = g_stage[STAGES-1].v_q;

`ifdef PIPELINED_ADDER_OVF_EN
  // The last stage's op_a/op_b MSBs are the original operand sign bits
  logic ovf_d;
  logic ovf_q;

  assign ovf_d = (g_stage[STAGES-1].op_a[SLICE-1] == g_stage[STAGES-1].op_b[SLICE-1])
              && (g_stage[STAGES-1].sum_d[WIDTH-1] != g_stage[STAGES-1].op_a[SLICE-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (rdy[STAGES-1]) begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - self-checking bench for pipelined_adder (WIDTH=8, STAGES=2)
// Queue-based arithmetic model checked every cycle plus directed literal expectations.
module tb_pipelined_adder;
  localparam int W = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         out_valid;
  logic         out_ready;
  logic         ovf_bit;

`ifdef PIPELINED_ADDER_OVF_EN
  logic overflow;
  assign ovf_bit = overflow;
  localparam logic [9:0] MASK = 10'h3FF;
`else
  assign ovf_bit = 1'b0;
  localparam logic [9:0] MASK = 10'h1FF;
`endif

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .out_valid (out_valid),
`ifdef PIPELINED_ADDER_OVF_EN
    .overflow  (overflow),
`endif
    .out_ready (out_ready)
  );

  int checks   = 0;
  int failures = 0;
  int pops     = 0;
  logic [9:0] exp_q[$];

  // {signed_overflow, carry, sum} from plain integer arithmetic
  function automatic logic [9:0] model(logic [7:0] x, logic [7:0] y, logic c);
    int us;
    int ss;
    logic ov;
    us = int'(x) + int'(y) + int'(c);
    ss = int'($signed(x)) + int'($signed(y)) + int'(c);
    ov = (ss > 127) || (ss < -128);
    return {ov, us[8:0]};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic       prev_stall = 1'b0;
  logic [9:0] prev_out   = '0;

  always @(negedge clk) begin
    logic [9:0] cur;
    cur = {ovf_bit, carry_out, sum};
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_hold_data", cur, prev_out);
        chk("stall_hold_valid", out_valid, 1);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", out_valid, 0);
        end else begin
          chk("result_vs_model", cur & MASK, exp_q[0] & MASK);
          if (out_ready) begin
            void'(exp_q.pop_front());
            pops++;
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, carry_in));
      prev_stall = out_valid && !out_ready;
      prev_out   = cur;
    end
  end

  logic [16:0] vec [8] = '{
    {8'h00, 8'h00, 1'b0}, {8'hFF, 8'hFF, 1'b1}, {8'h7F, 8'h7F, 1'b0}, {8'h80, 8'h7F, 1'b1},
    {8'hA5, 8'h5A, 1'b0}, {8'h0F, 8'hF1, 1'b0}, {8'h33, 8'hCC, 1'b1}, {8'h01, 8'hFE, 1'b1}
  };

  initial begin
    int p0;
    int cyc;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_sum", sum, 8'h00);
    chk("reset_carry_out", carry_out, 0);
    chk("reset_in_ready", in_ready, 1);
`ifdef PIPELINED_ADDER_OVF_EN
    chk("reset_overflow", overflow, 0);
`endif

    // single transaction, latency 2
    a = 8'hFF; b = 8'h01; carry_in = 1'b0; in_valid = 1'b1;
    chk("single_in_ready", in_ready, 1);
    step(); in_valid = 1'b0;
    chk("single_not_early", out_valid, 0);
    step();
    chk("single_valid", out_valid, 1);
    chk("single_sum", sum, 8'h00);
    chk("single_carry", carry_out, 1);
    step();
    chk("single_gone", out_valid, 0);

    // back-to-back
    a = 8'h12; b = 8'h34; carry_in = 1'b1; in_valid = 1'b1;
    step();
    a = 8'h80; b = 8'h80; carry_in = 1'b0;
    step(); in_valid = 1'b0;
    chk("b2b_r1_valid", out_valid, 1);
    chk("b2b_r1_sum", sum, 8'h47);
    chk("b2b_r1_carry", carry_out, 0);
    step();
    chk("b2b_r2_valid", out_valid, 1);
    chk("b2b_r2_sum", sum, 8'h00);
    chk("b2b_r2_carry", carry_out, 1);
    step();
    chk("b2b_empty", out_valid, 0);

    // wrap-around
    a = 8'hFF; b = 8'h00; carry_in = 1'b1; in_valid = 1'b1;
    step(); in_valid = 1'b0;
    step();
    chk("wrap_sum", sum, 8'h00);
    chk("wrap_carry", carry_out, 1);
`ifdef PIPELINED_ADDER_OVF_EN
    chk("wrap_ovf", overflow, 0);
    a = 8'h7F; b = 8'h01; carry_in = 1'b0; in_valid = 1'b1;
    step();
    a = 8'hFF; b = 8'h01;
    step(); in_valid = 1'b0;
    chk("ovf_pos_sum", sum, 8'h80);
    chk("ovf_pos_flag", overflow, 1);
    step();
    chk("ovf_neg_flag", overflow, 0);
`endif
    step();

    // backpressure
    out_ready = 1'b0;
    a = 8'h01; b = 8'h02; carry_in = 1'b0; in_valid = 1'b1;
    step();
    chk("bp_fill_ready", in_ready, 1);
    a = 8'hF0; b = 8'h20; carry_in = 1'b1;
    step();
    a = 8'h55; b = 8'hAA; carry_in = 1'b1;
    chk("bp_full_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_sum", sum, 8'h03);
      chk("bp_hold_carry", carry_out, 0);
      step();
    end
    p0 = pops;
    out_ready = 1'b1;
    #1;
    chk("bp_ready_through", in_ready, 1);
    step(); in_valid = 1'b0;
    chk("bp_r2_sum", sum, 8'h11);
    chk("bp_r2_carry", carry_out, 1);
    step();
    chk("bp_r3_sum", sum, 8'h00);
    chk("bp_r3_carry", carry_out, 1);
    step();
    chk("bp_drained", out_valid, 0);
    chk("bp_pop_count", pops - p0, 3);
    chk("bp_queue_empty", exp_q.size(), 0);

    // reset mid-flight
    a = 8'h0F; b = 8'h01; carry_in = 1'b0; in_valid = 1'b1;
    step(); in_valid = 1'b0; rst = 1'b1;
    step(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("midrst_no_out", out_valid, 0);
      step();
    end

    // directed stream with intermittent backpressure
    cyc = 0;
    for (int i = 0; i < 8; i++) begin
      {a, b, carry_in} = vec[i];
      in_valid = 1'b1;
      for (int t = 0; t < 20; t++) begin
        out_ready = (cyc % 3) != 2;
        cyc++;
        #1;
        if (in_ready) begin
          step();
          break;
        end
        step();
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) step();
    chk("stream_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
